bn_param_loader: RTL and testbench

//  Producer side of the batch-normalization parameter interface. Takes a byte stream of
//  {BN_factor, BN_addend} pairs and fills a shadow bank with one pair per neuron.

---
 rtl/bn_pkg.sv | 33 +++
 rtl/bn_code_checker.sv | 18 +
 rtl/bn_param_loader.sv | 117 +++++++++++
 tb/tb_bn_param_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// Shared definitions for the batch-normalization parameter loader.
// Factor codes, loader state encoding and the pair legality rule.
package bn_pkg;

   localparam logic [3:0] BN_F_X0    = 4'b0000;
   localparam logic [3:0] BN_F_X0_25 = 4'b1000;
   localparam logic [3:0] BN_F_X0_5  = 4'b0001;
   localparam logic [3:0] BN_F_X1    = 4'b0100;
   localparam logic [3:0] BN_F_X2    = 4'b0010;
   localparam logic [3:0] BN_F_X4    = 4'b1100;
   localparam logic [3:0] BN_F_X8    = 4'b0011;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMMIT
   } bn_state_t;

   // Gains above 8x are not representable; at 8x any offset would overflow.
   function automatic logic bn_pair_legal(
      input logic [3:0] factor,
      input logic [3:0] addend
   );
      logic ok;
      ok = 1'b1;
      if (factor == 4'b0111 || factor == 4'b1011 || factor == 4'b1111)
         ok = 1'b0;
      if (factor == BN_F_X8 && addend != 4'd0)
         ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/bn_code_checker.sv
// Combinational legality check of one {factor, addend} pair.
// Only instantiated when BN_PARAM_CHECK_EN is defined.
module bn_code_checker
   import bn_pkg::*;
#(
   parameter int ADDEND_WIDTH = 4
) (
   input  logic [3:0]              factor,
   input  logic [ADDEND_WIDTH-1:0] addend,
   output logic                    legal
);

   logic [3:0] addend_ext;

   assign addend_ext = 4'(addend);
   assign legal      = bn_pair_legal(factor, addend_ext);

endmodule

// File: rtl/bn_param_loader.sv
// Streams {factor, addend} bytes into a shadow bank, commits it atomically.
// Define BN_PARAM_CHECK_EN to reject banks containing illegal pairs.
module bn_param_loader
   import bn_pkg::*;
#(
   parameter int NEURONS      = 8,
   parameter int ADDEND_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [7:0]                      data_in,
   input  logic                            data_valid,
   output logic                            data_ready,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [4*NEURONS-1:0]            factor_out,
   output logic [ADDEND_WIDTH*NEURONS-1:0] addend_out
);

   localparam int IW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

   localparam logic [4*NEURONS-1:0] ID_F = {NEURONS{BN_F_X1}};
   localparam logic [ADDEND_WIDTH*NEURONS-1:0] ID_A = '0;

   bn_state_t                       state;
   logic [IW-1:0]                   idx;
   logic [4*NEURONS-1:0]            shadow_f;
   logic [ADDEND_WIDTH*NEURONS-1:0] shadow_a;
   logic                            xfer;
   logic                            last;

   // start takes priority over a transfer in the same cycle
   assign xfer = data_valid & data_ready & ~start;
   assign last = (idx == IW'(NEURONS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         data_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         shadow_f   <= ID_F;
         shadow_a   <= ID_A;
         factor_out <= ID_F;
         addend_out <= ID_A;
      end else begin
         done <= 1'b0;
         if (state == COMMIT && !error) begin
            factor_out <= shadow_f;
            addend_out <= shadow_a;
         end
         if (start) begin
            state      <= LOAD;
            idx        <= '0;
            data_ready <= 1'b1;
            busy       <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  data_ready <= 1'b0;
                  busy       <= 1'b0;
               end
               LOAD: begin
                  if (xfer) begin
                     shadow_f[4*idx +: 4] <= data_in[7:4];
                     shadow_a[ADDEND_WIDTH*idx +: ADDEND_WIDTH]
                        <= data_in[ADDEND_WIDTH-1:0];
                     idx <= idx + 1'b1;
                     if (last) begin
                        state      <= COMMIT;
                        idx        <= '0;
                        data_ready <= 1'b0;
                        done       <= 1'b1;
                     end
                  end
               end
               COMMIT: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state      <= IDLE;
                  data_ready <= 1'b0;
                  busy       <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef BN_PARAM_CHECK_EN
   logic pair_ok;

   bn_code_checker #(
      .ADDEND_WIDTH(ADDEND_WIDTH)
   ) u_chk (
      .factor(data_in[7:4]),
      .addend(data_in[ADDEND_WIDTH-1:0]),
      .legal (pair_ok)
   );

   always_ff @(posedge clk) begin
      if (reset)
         error <= 1'b0;
      else if (start)
         error <= 1'b0;
      else if (state == LOAD && xfer && !pair_ok)
         error <= 1'b1;
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bn_param_loader.sv
// Randomized self-checking bench for bn_param_loader (NEURONS=4, ADDEND_WIDTH=4).
// Expected banks come from a slot-array model built from the loaded bytes.
module tb_bn_param_loader;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] factor_out;
   logic [15:0] addend_out;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [3:0] m_f [N];
   logic [3:0] m_a [N];
   logic [7:0] ld [N];

   bn_param_loader #(
      .NEURONS(N),
      .ADDEND_WIDTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .data_in(data_in),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .busy(busy),
      .done(done),
      .error(error),
      .factor_out(factor_out),
      .addend_out(addend_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (done === 1'b1) done_cnt++;

   function automatic bit legal_m(input logic [7:0] b);
`ifdef BN_PARAM_CHECK_EN
      int f;
      f = int'(b[7:4]);
      if (f == 7 || f == 11 || f == 15) return 1'b0;
      if (f == 3 && b[3:0] != 4'd0) return 1'b0;
      return 1'b1;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [15:0] exp_f();
      logic [15:0] r;
      for (int i = 0; i < N; i++) r[4*i +: 4] = m_f[i];
      return r;
   endfunction

   function automatic logic [15:0] exp_a();
      logic [15:0] r;
      for (int i = 0; i < N; i++) r[4*i +: 4] = m_a[i];
      return r;
   endfunction

   task automatic model_identity();
      for (int i = 0; i < N; i++) begin
         m_f[i] = 4'b0100;
         m_a[i] = 4'b0000;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_bank(input string nm);
      checks++;
      if (factor_out !== exp_f() || addend_out !== exp_a()) begin
         errors++;
         $display("FAIL %s: factor %h addend %h, want factor %h addend %h",
                  nm, factor_out, addend_out, exp_f(), exp_a());
      end
   endtask

   // Send ld[lo..N-1] with random idle gaps; returns whether any was illegal.
   task automatic send_bytes(input int lo, input int maxgap,
                             output bit bad);
      int w;
      bad = 1'b0;
      for (int i = lo; i < N; i++) begin
         for (int g = $urandom_range(0, maxgap); g > 0; g--) begin
            data_valid = 1'b0;
            data_in    = 8'($urandom);
            tick();
         end
         data_in    = ld[i];
         data_valid = 1'b1;
         w = 0;
         while (data_ready !== 1'b1 && w < 10) begin
            tick();
            w++;
         end
         if (w == 10) begin
            errors++;
            $display("FAIL ready_timeout: data_ready %b, want 1", data_ready);
         end
         tick();
         data_valid = 1'b0;
         if (!legal_m(ld[i])) bad = 1'b1;
      end
   endtask

   // Called in the cycle right after the last byte was accepted.
   task automatic finish_load(input string nm, input bit bad,
                              input int dc0);
      checks++;
      if (done !== 1'b1 || data_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_commit: done %b ready %b busy %b, want 1 0 1",
                  nm, done, data_ready, busy);
      end
      checks++;
      if (error !== bad) begin
         errors++;
         $display("FAIL %s_error: error %b, want %b", nm, error, bad);
      end
      tick();
      if (!bad)
         for (int i = 0; i < N; i++) begin
            m_f[i] = ld[i][7:4];
            m_a[i] = ld[i][3:0];
         end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || done_cnt != dc0 + 1) begin
         errors++;
         $display("FAIL %s_end: done %b busy %b pulses %0d, want 0 0 %0d",
                  nm, done, busy, done_cnt - dc0, 1);
      end
      check_bank({nm, "_bank"});
   endtask

   task automatic run_load(input string nm, input int maxgap);
      bit bad;
      int dc0;
      dc0 = done_cnt;
      pulse_start();
      send_bytes(0, maxgap, bad);
      finish_load(nm, bad, dc0);
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      start      = 1'b0;
      data_valid = 1'b0;
      data_in    = 8'h00;
      model_identity();
      repeat (2) tick();
      reset = 1'b0;
      checks++;
      if (data_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          error !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready %b busy %b done %b error %b, want 0",
                  data_ready, busy, done, error);
      end
      checks++;
      if (factor_out !== 16'h4444 || addend_out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_bank: factor %h addend %h, want 4444 0000",
                  factor_out, addend_out);
      end
   endtask

   task automatic test_idle_ignore();
      data_in    = 8'h3F;
      data_valid = 1'b1;
      repeat (3) tick();
      data_valid = 1'b0;
      checks++;
      if (data_ready !== 1'b0 || busy !== 1'b0 || done_cnt != 0) begin
         errors++;
         $display("FAIL idle_ignore: ready %b busy %b pulses %0d, want 0 0 0",
                  data_ready, busy, done_cnt);
      end
      check_bank("idle_bank");
   endtask

   task automatic test_basic();
      ld = '{8'h12, 8'h24, 8'hC0, 8'h1F};
      run_load("basic", 0);
      checks++;
      if (factor_out !== 16'h1C21 || addend_out !== 16'hF042) begin
         errors++;
         $display("FAIL basic_const: factor %h addend %h, want 1C21 F042",
                  factor_out, addend_out);
      end
   endtask

   task automatic test_check();
      ld = '{8'h41, 8'h70, 8'h41, 8'h41};
      run_load("chk_f7", 1);
      ld = '{8'h41, 8'h41, 8'h31, 8'h41};
      run_load("chk_x8_off", 1);
      ld = '{8'h41, 8'h41, 8'h30, 8'h41};
      run_load("chk_x8_ok", 1);
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL chk_clear: error %b, want 0", error);
      end
   endtask

   task automatic test_restart();
      bit bad;
      int dc0;
      dc0 = done_cnt;
      ld = '{8'h70, 8'h31, 8'h00, 8'h00};
      pulse_start();
      send_bytes(2, 1, bad);
      start      = 1'b1;
      data_valid = 1'b1;
      data_in    = 8'h77;
      tick();
      start      = 1'b0;
      data_valid = 1'b0;
      checks++;
      if (data_ready !== 1'b1 || error !== 1'b0 || done_cnt != dc0) begin
         errors++;
         $display("FAIL restart_state: ready %b error %b pulses %0d, want 1 0 0",
                  data_ready, error, done_cnt - dc0);
      end
      ld = '{8'h22, 8'h22, 8'h22, 8'h22};
      send_bytes(0, 2, bad);
      finish_load("restart", bad, dc0);
      checks++;
      if (factor_out !== 16'h2222 || addend_out !== 16'h2222) begin
         errors++;
         $display("FAIL restart_const: factor %h addend %h, want 2222 2222",
                  factor_out, addend_out);
      end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) ld[i] = {4'b0010, 4'($urandom)};
         run_load("stall", 4);
      end
   endtask

   task automatic test_commit_restart();
      bit bad;
      int dc0;
      dc0 = done_cnt;
      ld = '{8'h81, 8'h13, 8'hCE, 8'h47};
      pulse_start();
      send_bytes(0, 1, bad);
      start = 1'b1;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL crs_done: done %b, want 1", done);
      end
      tick();
      start = 1'b0;
      if (!bad)
         for (int i = 0; i < N; i++) begin
            m_f[i] = ld[i][7:4];
            m_a[i] = ld[i][3:0];
         end
      checks++;
      if (data_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL crs_reload: ready %b busy %b done %b, want 1 1 0",
                  data_ready, busy, done);
      end
      check_bank("crs_bank");
      dc0 = done_cnt;
      ld = '{8'h10, 8'h20, 8'h40, 8'h80};
      send_bytes(0, 1, bad);
      finish_load("crs_second", bad, dc0);
   endtask

   task automatic test_reset_mid();
      bit bad;
      ld = '{8'hC1, 8'h12, 8'h00, 8'h00};
      pulse_start();
      send_bytes(2, 1, bad);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_identity();
      checks++;
      if (busy !== 1'b0 || data_ready !== 1'b0 || error !== 1'b0 ||
          done !== 1'b0) begin
         errors++;
         $display("FAIL rmid_ctrl: busy %b ready %b error %b done %b, want 0",
                  busy, data_ready, error, done);
      end
      check_bank("rmid_bank");
      ld = '{8'h2A, 8'hC3, 8'h05, 8'h89};
      run_load("rmid_after", 1);
   endtask

   task automatic test_random();
      logic [3:0] codes [7];
      codes = '{4'b0000, 4'b1000, 4'b0001, 4'b0100, 4'b0010,
                4'b1100, 4'b0011};
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0)
               ld[i] = 8'($urandom);
            else
               ld[i] = {codes[$urandom_range(0, 6)], 4'($urandom)};
         end
         run_load("random", 3);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_basic();
      test_check();
      test_restart();
      test_stall();
      test_commit_restart();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
